// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and ALU control, and counts retired instructions.
module multicycle_controller #(
   parameter int OP_WIDTH_P        = 6,
   parameter int FUNCT_WIDTH_P     = 6,
   parameter int ALU_CNTRL_WIDTH_P = 3,
   parameter int CNT_WIDTH_P       = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [OP_WIDTH_P-1:0]        i_opcode,
   input  logic [FUNCT_WIDTH_P-1:0]     i_function,
   input  logic                         i_alu_zero,
   input  logic                         i_mem_ready,
   output logic                         o_mem_req,
   output logic                         o_mem_wr_en,
   output logic                         o_iord,
   output logic                         o_ir_wr_en,
   output logic                         o_pc_en,
   output logic [1:0]                   o_pc_src_sel,
   output logic                         o_alu_src_a_sel,
   output logic [1:0]                   o_alu_src_b_sel,
   output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
   output logic                         o_reg_wr_en,
   output logic                         o_reg_wr_addr_sel,
   output logic                         o_reg_wr_data_sel,
   output logic                         o_illegal,
   output logic [CNT_WIDTH_P-1:0]       o_retired,
   output logic [3:0]                   o_state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_ADDIEX  = 4'd8,
      S_ADDIWB  = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_ERROR   = 4'd12
   } state_t;

   localparam logic [OP_WIDTH_P-1:0] OP_RTYPE = OP_WIDTH_P'(6'b000000);
   localparam logic [OP_WIDTH_P-1:0] OP_LW    = OP_WIDTH_P'(6'b100011);
   localparam logic [OP_WIDTH_P-1:0] OP_SW    = OP_WIDTH_P'(6'b101011);
   localparam logic [OP_WIDTH_P-1:0] OP_BEQ   = OP_WIDTH_P'(6'b000100);
   localparam logic [OP_WIDTH_P-1:0] OP_ADDI  = OP_WIDTH_P'(6'b001000);
   localparam logic [OP_WIDTH_P-1:0] OP_J     = OP_WIDTH_P'(6'b000010);

   localparam logic [FUNCT_WIDTH_P-1:0] FN_ADD = FUNCT_WIDTH_P'(6'b100000);
   localparam logic [FUNCT_WIDTH_P-1:0] FN_SUB = FUNCT_WIDTH_P'(6'b100010);
   localparam logic [FUNCT_WIDTH_P-1:0] FN_AND = FUNCT_WIDTH_P'(6'b100100);
   localparam logic [FUNCT_WIDTH_P-1:0] FN_OR  = FUNCT_WIDTH_P'(6'b100101);
   localparam logic [FUNCT_WIDTH_P-1:0] FN_SLT = FUNCT_WIDTH_P'(6'b101010);

   localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_ADD = ALU_CNTRL_WIDTH_P'(3'b010);
   localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SUB = ALU_CNTRL_WIDTH_P'(3'b110);
   localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_AND = ALU_CNTRL_WIDTH_P'(3'b000);
   localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_OR  = ALU_CNTRL_WIDTH_P'(3'b001);
   localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SLT = ALU_CNTRL_WIDTH_P'(3'b111);

   state_t                         r_state;
   state_t                         w_next;
   logic [CNT_WIDTH_P-1:0]         r_retired;
   logic                           w_retire;
   logic                           w_funct_ok;
   logic [ALU_CNTRL_WIDTH_P-1:0]   w_funct_alu;

   // Funct decode is shared by the DECODE legality check and the EXECUTE ALU op.
   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = ALU_ADD;
      case (i_function)
         FN_ADD:  w_funct_alu = ALU_ADD;
         FN_SUB:  w_funct_alu = ALU_SUB;
         FN_AND:  w_funct_alu = ALU_AND;
         FN_OR:   w_funct_alu = ALU_OR;
         FN_SLT:  w_funct_alu = ALU_SLT;
         default: w_funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:   if (i_mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (i_opcode)
               OP_RTYPE:     w_next = w_funct_ok ? S_EXECUTE : S_ERROR;
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_ERROR;
            endcase
         end
         S_MEMADR:  w_next = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (i_mem_ready) w_next = S_MEMWB;
         S_MEMWR:   if (i_mem_ready) w_next = S_FETCH;
         S_EXECUTE: w_next = S_ALUWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         S_ERROR:   w_next = S_ERROR;
         default:   w_next = S_FETCH;
      endcase
   end

   always_comb begin
      o_mem_req         = 1'b0;
      o_mem_wr_en       = 1'b0;
      o_iord            = 1'b0;
      o_ir_wr_en        = 1'b0;
      o_pc_en           = 1'b0;
      o_pc_src_sel      = 2'b00;
      o_alu_src_a_sel   = 1'b0;
      o_alu_src_b_sel   = 2'b00;
      o_alu_cntrl       = ALU_ADD;
      o_reg_wr_en       = 1'b0;
      o_reg_wr_addr_sel = 1'b0;
      o_reg_wr_data_sel = 1'b0;
      o_illegal         = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_req       = 1'b1;
            o_ir_wr_en      = i_mem_ready;
            o_pc_en         = i_mem_ready;
            o_alu_src_b_sel = 2'b01;
         end
         S_DECODE:  o_alu_src_b_sel = 2'b11;
         S_MEMADR: begin
            o_alu_src_a_sel = 1'b1;
            o_alu_src_b_sel = 2'b10;
         end
         S_MEMRD: begin
            o_mem_req = 1'b1;
            o_iord    = 1'b1;
         end
         S_MEMWB: begin
            o_reg_wr_en       = 1'b1;
            o_reg_wr_data_sel = 1'b1;
         end
         S_MEMWR: begin
            o_mem_req   = 1'b1;
            o_mem_wr_en = 1'b1;
            o_iord      = 1'b1;
         end
         S_EXECUTE: begin
            o_alu_src_a_sel = 1'b1;
            o_alu_cntrl     = w_funct_alu;
         end
         S_ALUWB: begin
            o_reg_wr_en       = 1'b1;
            o_reg_wr_addr_sel = 1'b1;
         end
         S_ADDIEX: begin
            o_alu_src_a_sel = 1'b1;
            o_alu_src_b_sel = 2'b10;
         end
         S_ADDIWB:  o_reg_wr_en = 1'b1;
         S_BRANCH: begin
            o_alu_src_a_sel = 1'b1;
            o_alu_cntrl     = ALU_SUB;
            o_pc_src_sel    = 2'b01;
            o_pc_en         = i_alu_zero;
         end
         S_JUMP: begin
            o_pc_src_sel = 2'b10;
            o_pc_en      = 1'b1;
         end
         // ERROR is terminal; ERROR itself holds the sticky illegal flag.
         S_ERROR: begin
            o_alu_cntrl = '0;
            o_illegal   = 1'b1;
         end
         default: o_alu_cntrl = ALU_ADD;
      endcase
      if (i_rst) begin
         o_mem_req         = 1'b0;
         o_mem_wr_en       = 1'b0;
         o_iord            = 1'b0;
         o_ir_wr_en        = 1'b0;
         o_pc_en           = 1'b0;
         o_pc_src_sel      = 2'b00;
         o_alu_src_a_sel   = 1'b0;
         o_alu_src_b_sel   = 2'b00;
         o_alu_cntrl       = '0;
         o_reg_wr_en       = 1'b0;
         o_reg_wr_addr_sel = 1'b0;
         o_reg_wr_data_sel = 1'b0;
         o_illegal         = 1'b0;
      end
   end

   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_retire = 1'b1;
         S_MEMWR: w_retire = i_mem_ready;
         default: w_retire = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_WIDTH_P'(1);
      end
   end

   assign o_retired = r_retired;
   assign o_state   = r_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control FSM for the shared-memory MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback over several cycles, driving the datapath mux selects, enables and ALU control. It handshakes with a single unified instruction/data memory and counts retired instructions. It replaces the single-cycle opcode/ALU decoder in the multi-cycle core.

Parameters:
OP_WIDTH_P, 6, opcode field width
FUNCT_WIDTH_P, 6, funct field width
ALU_CNTRL_WIDTH_P, 3, ALU control width
CNT_WIDTH_P, 32, retired-instruction counter width

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_opcode  input  OP_WIDTH_P  opcode from instruction register
i_function  input  FUNCT_WIDTH_P  funct from instruction register
i_alu_zero  input  1  ALU zero flag
i_mem_ready  input  1  memory completes current request this cycle
o_mem_req  output  1  memory access request
o_mem_wr_en  output  1  memory write (qualifies o_mem_req)
o_iord  output  1  memory address select: 0=PC, 1=ALU out
o_ir_wr_en  output  1  instruction register load
o_pc_en  output  1  PC load
o_pc_src_sel  output  2  00=ALU result, 01=ALU out reg (branch target), 10=jump target
o_alu_src_a_sel  output  1  0=PC, 1=reg A
o_alu_src_b_sel  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
o_alu_cntrl  output  ALU_CNTRL_WIDTH_P  010 add, 110 sub, 000 and, 001 or, 111 slt
o_reg_wr_en  output  1  register file write
o_reg_wr_addr_sel  output  1  0=rt, 1=rd
o_reg_wr_data_sel  output  1  0=ALU out, 1=memory data
o_illegal  output  1  sticky illegal-instruction flag
o_retired  output  CNT_WIDTH_P  retired-instruction count
o_state  output  4  current state encoding, debug

Behaviour:
- Reset (async, i_rst=1): state=FETCH, o_retired=0, o_illegal=0; all other outputs forced 0 while i_rst high.
- Outputs decoded from state (Moore), except o_ir_wr_en and o_pc_en (see FETCH/BRANCH). Signals not listed for a state are 0; o_alu_cntrl defaults to 010.
- FETCH: o_mem_req=1, o_iord=0, src_a=0, src_b=01, add, pc_src=00; o_ir_wr_en=o_pc_en=i_mem_ready. Stays in FETCH until i_mem_ready, then DECODE.
- DECODE: src_a=0, src_b=11, add (branch target precompute). Next: 000000 with funct in {100000,100010,100100,100101,101010} -> EXECUTE; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode, or R-type with other funct -> ERROR.
- MEMADR: src_a=1, src_b=10, add; -> MEMRD (lw) / MEMWR (sw).
- MEMRD: o_mem_req=1, o_iord=1; hold until i_mem_ready, then MEMWB.
- MEMWB: reg_wr_en=1, addr_sel=0, data_sel=1; -> FETCH.
- MEMWR: o_mem_req=1, o_mem_wr_en=1, o_iord=1; hold until i_mem_ready, then FETCH.
- EXECUTE: src_a=1, src_b=00, alu_cntrl from funct (add/sub/and/or/slt); -> ALUWB.
- ALUWB: reg_wr_en=1, addr_sel=1, data_sel=0; -> FETCH.
- ADDIEX: src_a=1, src_b=10, add; -> ADDIWB.
- ADDIWB: reg_wr_en=1, addr_sel=0, data_sel=0; -> FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01, o_pc_en=i_alu_zero; -> FETCH.
- JUMP: pc_src=10, o_pc_en=1; -> FETCH.
- ERROR: all controls 0, o_illegal=1; terminal until reset. Not counted as retired.
- o_retired increments by 1 on each transition into FETCH from MEMWB, MEMWR(ready), ALUWB, ADDIWB, BRANCH, JUMP. Wraps to 0 at 2^CNT_WIDTH_P.
- Cycle counts at zero wait: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- i_mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset mid-instruction (including during a memory wait) aborts: o_mem_req drops immediately, no retire is counted.

Test Plan:
- R-type add (op 000000, funct 100000), i_mem_ready=1 always -> states FETCH,DECODE,EXECUTE(alu_cntrl 010),ALUWB(reg_wr_en=1, addr_sel=1); o_retired 0->1 after cycle 4.
- lw (100011), i_mem_ready low 3 cycles in MEMRD -> o_mem_req=1, o_iord=1 held 4 cycles; MEMWB has data_sel=1, addr_sel=0; total 8 cycles.
- beq (000100) with i_alu_zero=1 then 0 -> BRANCH o_pc_en=1, pc_src=01, alu 110 in the first case; o_pc_en=0 in the second; both retire.
- sw then j back-to-back -> MEMWR o_mem_wr_en=1 for one cycle; JUMP o_pc_en=1, pc_src=10; o_retired=2.
- Illegal opcode 111111, then R-type funct 000111 after reset -> ERROR, o_illegal=1 sticky, o_retired unchanged, no further o_mem_req.
- Assert i_rst during a MEMRD wait -> outputs 0 immediately; after release state=FETCH, o_retired=0, o_illegal=0.
